stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Run-control sequencer for the 4-digit BCD stopwatch counter. Debounces the
//   reset/run-pause buttons, latches mode and preset, generates the 100 Hz count
//   step, detects the terminal count and commands the counter via load/step/dir.
//   Sits between the board buttons/switches and the BCD counter datapath.
//   The display scan is not part of this block.
// PARAMETERS
//   TICK_DIV   1_000_000  c_clk cycles per count step (100 MHz -> 10 ms, 0.01 s)
//   DB_CYCLES  1_000_000  consecutive stable samples before a button level is accepted
// PORTS
//   c_clk     in   1   system clock; all logic rising-edge
//   C_clr     in   1   reset, asynchronous, active-high
//   btn_r     in   1   reset button, raw/asynchronous
//   btn_p     in   1   run/pause button, raw/asynchronous
//   sel       in   2   mode: 0 up from 00.00, 1 up from preset, 2 down from 99.99, 3 down from preset
//   load      in   8   preset tens/units seconds, BCD {load[7:4],load[3:0]}
//   count     in   16  current BCD counter value from datapath
//   cnt_load  out  1   level: counter loads load_val synchronously while high
//   load_val  out  16  BCD value to load
//   cnt_step  out  1   1-cycle pulse: counter advances one count in direction cnt_up
//   cnt_up    out  1   1 = increment, 0 = decrement
//   state_o   out  2   FSM state (debug LEDs)
//   done      out  1   high in DONE
// BEHAVIOUR
//   Reset (C_clr high): state IDLE, prescaler 0, debounced levels 0, mode_q=0, load_q=0.
//     Outputs during reset: cnt_load=1, load_val=16'h0000, cnt_step=0, cnt_up=1,
//     state_o=2'b00, done=0.
//   Buttons: 2-FF synchroniser, then a stability counter. The debounced level takes
//     the synced value after DB_CYCLES consecutive equal samples. Any differing sample
//     zeroes the counter. Rising edge of debounced level -> 1-cycle r_press / p_press.
//   Mode/preset: mode_q<=sel and load_q<=load on every cycle while in IDLE; frozen in other states.
//     Preset digit >9 clamps to 9.
//     load_val: mode0 0000; mode1 {load_q,8'h00}; mode2 9999; mode3 {load_q,8'h00}.
//     cnt_up = ~mode_q[1].
//   Terminal: term = cnt_up ? (count==16'h9999) : (count==16'h0000).
//   FSM (state_o encoding). r_press has priority over everything:
//     IDLE  (00): cnt_load=1. p_press -> RUN; prescaler cleared on entry.
//     RUN   (01): prescaler counts 0..TICK_DIV-1 and wraps. At TICK_DIV-1 with !term,
//                 cnt_step=1 for that cycle. term -> DONE next cycle, no step issued.
//                 p_press -> PAUSE. r_press -> IDLE.
//     PAUSE (10): prescaler frozen (phase kept); p_press -> RUN; r_press -> IDLE.
//     DONE  (11): done=1, prescaler cleared; p_press ignored; r_press -> IDLE.
//   Same-cycle events:
//     - r_press with p_press -> IDLE.
//     - term with p_press in RUN -> DONE.
//     - Tick coinciding with p_press in RUN: step issued, then PAUSE.
//   cnt_load=0 and cnt_step=0 in every state except as stated. Outputs are registered
//     state decode, except cnt_step, which is combinational from the prescaler and state.
//   Latency: raw press -> state change = 2 (sync) + DB_CYCLES + 1 cycles.
//   Reset mid-run: immediate return to IDLE values; in-flight step and press pulses are dropped.
// TESTING (TICK_DIV=4, DB_CYCLES=3)
//   Reset, sel=0, press P -> RUN; cnt_step every 4 cycles; cnt_up=1; load_val=0000.
//   sel=3, load=8'h25 in IDLE -> load_val=16'h2500, cnt_up=0.
//     Change sel while in RUN -> load_val unchanged.
//   RUN with count forced to 9999 (sel=0) -> DONE next cycle, no step, done=1; P ignored; R -> IDLE.
//   P pulse of 2 cycles (shorter than DB_CYCLES) -> no state change.
//     Bouncing P then stable 3+ cycles -> exactly one RUN entry.
//   Pause at prescaler=2, resume -> first step 2 cycles after resume.
//     Simultaneous R+P press -> IDLE.
//   Assert C_clr mid-RUN -> outputs at reset values asynchronously.
//     Release -> IDLE, cnt_load=1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run-control sequencer for the BCD stopwatch counter.
// Debounces buttons, latches mode/preset, paces count steps and detects terminal count.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        c_clk,
  input  logic        C_clr,
  input  logic        btn_r,
  input  logic        btn_p,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic [15:0] count,
  output logic        cnt_load,
  output logic [15:0] load_val,
  output logic        cnt_step,
  output logic        cnt_up,
  output logic [1:0]  state_o,
  output logic        done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t state, nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [1:0] raw, s1, s2, lvl, lvl_d;
  logic [1:0] mode_q;
  logic [7:0] load_q;
  logic r_press, p_press, term, tick;
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return d > 4'd9 ? 4'd9 : d;
  endfunction
  assign raw = {btn_r, btn_p};
  always_ff @(posedge c_clk or posedge C_clr)
    if (C_clr) begin
      s1 <= '0;
      s2 <= '0;
      lvl_d <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_d <= lvl;
    end
  // Level flips only after DB_CYCLES consecutive synced samples disagree with it.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic l;
    always_ff @(posedge c_clk or posedge C_clr)
      if (C_clr) begin
        cnt <= '0;
        l <= 1'b0;
      end else if (s2[i] == l) cnt <= '0;
      else if (cnt == DW'(DB_CYCLES - 1)) begin
        cnt <= '0;
        l <= s2[i];
      end else cnt <= cnt + 1'b1;
    assign lvl[i] = l;
  end
  assign r_press  = lvl[1] & ~lvl_d[1];
  assign p_press  = lvl[0] & ~lvl_d[0];
  assign cnt_up   = ~mode_q[1];
  assign term     = cnt_up ? (count == 16'h9999) : (count == 16'h0000);
  assign tick     = psc == PW'(TICK_DIV - 1);
  assign load_val = mode_q == 2'd0 ? 16'h0000 : mode_q == 2'd2 ? 16'h9999 : {load_q, 8'h00};
  assign cnt_load = state == IDLE;
  assign done     = state == DONE;
  assign state_o  = state;
  always_comb begin
    nxt = r_press ? IDLE :
          state == IDLE  ? (p_press ? RUN : IDLE) :
          state == RUN   ? (term ? DONE : p_press ? PAUSE : RUN) :
          state == PAUSE ? (p_press ? RUN : PAUSE) : DONE;
    psc_nxt = (nxt == IDLE || nxt == DONE) ? '0 :
              state == RUN ? (tick ? '0 : psc + 1'b1) :
              state == PAUSE ? psc : '0;
    cnt_step = state == RUN && tick && !term && !r_press;
  end
  always_ff @(posedge c_clk or posedge C_clr)
    if (C_clr) begin
      state <= IDLE;
      psc <= '0;
      mode_q <= '0;
      load_q <= '0;
    end else begin
      state <= nxt;
      psc <= psc_nxt;
      if (state == IDLE) begin
        mode_q <= sel;
        load_q <= {clamp9(load[7:4]), clamp9(load[3:0])};
      end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized scoreboard bench for stopwatch_ctrl against a
// cycle-level reference model of the run-control rules.
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;
  logic c_clk, C_clr, btn_r, btn_p;
  logic [1:0] sel;
  logic [7:0] load;
  logic [15:0] count;
  logic cnt_load, cnt_step, cnt_up, done;
  logic [15:0] load_val;
  logic [1:0] state_o;
  int n_cmp = 0, n_bad = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .c_clk(c_clk), .C_clr(C_clr), .btn_r(btn_r), .btn_p(btn_p), .sel(sel), .load(load),
    .count(count), .cnt_load(cnt_load), .load_val(load_val), .cnt_step(cnt_step),
    .cnt_up(cnt_up), .state_o(state_o), .done(done));

  initial c_clk = 0;
  always #5 c_clk = ~c_clk;

  typedef struct packed {
    logic ld; logic [15:0] lv; logic st; logic up; logic [1:0] so; logic dn;
  } obs_t;
  obs_t exp_q[$];

  // Reference model: states 0 idle, 1 run, 2 pause, 3 done
  int m_state, m_phase, m_mode, ns;
  logic [7:0] m_preset;
  logic [1:0] rawq[$], synq[$], m_lvl, m_press;
  logic m_term, flip;
  obs_t e;

  function automatic logic [3:0] c9(input logic [3:0] d);
    return d > 4'd9 ? 4'd9 : d;
  endfunction

  function automatic logic is_term(input int mode, input logic [15:0] c);
    return mode < 2 ? (c == 16'h9999) : (c == 16'h0000);
  endfunction

  always @(posedge c_clk or posedge C_clr)
    if (C_clr) begin
      m_state = 0; m_phase = 0; m_mode = 0; m_preset = 0;
      rawq = '{2'b00, 2'b00}; synq.delete();
      m_lvl = 0; m_press = 0;
      exp_q.delete();
    end else begin
      m_term = is_term(m_mode, count);
      if (m_press[1]) ns = 0;
      else case (m_state)
        0: ns = m_press[0] ? 1 : 0;
        1: ns = m_term ? 3 : (m_press[0] ? 2 : 1);
        2: ns = m_press[0] ? 1 : 2;
        default: ns = 3;
      endcase
      if (ns == 0 || ns == 3 || m_state == 0) m_phase = 0;
      else if (m_state == 1) m_phase = (m_phase + 1) % TD;
      if (m_state == 0) begin
        m_mode = int'(sel);
        m_preset = {c9(load[7:4]), c9(load[3:0])};
      end
      m_state = ns;
      rawq.push_back({btn_r, btn_p});
      synq.push_back(rawq.pop_front());
      if (synq.size() > DB) void'(synq.pop_front());
      for (int b = 0; b < 2; b++) begin
        flip = synq.size() == DB;
        for (int j = 0; j < synq.size(); j++) if (synq[j][b] == m_lvl[b]) flip = 0;
        m_press[b] = flip && !m_lvl[b];
        if (flip) m_lvl[b] = ~m_lvl[b];
      end
      e.ld = m_state == 0;
      e.lv = m_mode == 0 ? 16'h0000 : m_mode == 2 ? 16'h9999 : {m_preset, 8'h00};
      e.st = m_state == 1 && m_phase == TD - 1 && !is_term(m_mode, count) && !m_press[1];
      e.up = m_mode < 2;
      e.so = 2'(m_state);
      e.dn = m_state == 3;
      exp_q.push_back(e);
    end

  always @(posedge c_clk) begin
    obs_t got, x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      got = {cnt_load, load_val, cnt_step, cnt_up, state_o, done};
      n_cmp++;
      if (got !== x) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got ld=%b lv=%h st=%b up=%b so=%0d dn=%b exp ld=%b lv=%h st=%b up=%b so=%0d dn=%b",
                 $time, got.ld, got.lv, got.st, got.up, got.so, got.dn, x.ld, x.lv, x.st, x.up, x.so, x.dn);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge c_clk);
  endtask

  task automatic press(input logic r, input logic p, input int hold);
    btn_r = r; btn_p = p;
    cyc(hold);
    btn_r = 0; btn_p = 0;
    cyc(8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"}, 16'(cnt_load), 16'h1);
    chk({tag, "_val"}, load_val, 16'h0000);
    chk({tag, "_step"}, 16'(cnt_step), 16'h0);
    chk({tag, "_up"}, 16'(cnt_up), 16'h1);
    chk({tag, "_state"}, 16'(state_o), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
  endtask

  initial begin
    C_clr = 1; btn_r = 0; btn_p = 0; sel = 0; load = 0; count = 16'h0123;
    cyc(3);
    chk_reset_vals("rst");
    C_clr = 0;
    cyc(2);
    press(0, 1, 4);
    cyc(12);
    chk("run_state", 16'(state_o), 16'h1);
    chk("run_val", load_val, 16'h0000);
    press(1, 0, 4);
    chk("r_idle", 16'(state_o), 16'h0);
    sel = 3; load = 8'h25;
    cyc(2);
    chk("preset_val", load_val, 16'h2500);
    chk("preset_up", 16'(cnt_up), 16'h0);
    press(0, 1, 4);
    sel = 0; load = 8'h99;
    cyc(5);
    chk("frozen_val", load_val, 16'h2500);
    chk("frozen_state", 16'(state_o), 16'h1);
    press(1, 0, 4);
    sel = 0; load = 8'hab;
    cyc(2);
    press(0, 1, 4);
    cyc(5);
    count = 16'h9999;
    cyc(2);
    chk("term_state", 16'(state_o), 16'h3);
    chk("term_done", 16'(done), 16'h1);
    press(0, 1, 4);
    chk("done_p_ignored", 16'(state_o), 16'h3);
    press(1, 0, 4);
    chk("done_r_idle", 16'(state_o), 16'h0);
    count = 16'h0456;
    press(0, 1, 2);
    chk("short_pulse", 16'(state_o), 16'h0);
    for (int k = 0; k < 6; k++) begin
      btn_p = ~btn_p;
      cyc(1);
    end
    press(0, 1, 5);
    chk("bounce_once", 16'(state_o), 16'h1);
    press(1, 1, 4);
    chk("rp_idle", 16'(state_o), 16'h0);
    press(0, 1, 4);
    cyc(3);
    #2 C_clr = 1;
    #1 chk_reset_vals("async");
    cyc(2);
    C_clr = 0;
    cyc(1);
    chk("post_rst_load", 16'(cnt_load), 16'h1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) btn_p = ~btn_p;
      if ($urandom_range(0, 49) == 0) btn_r = ~btn_r;
      if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) load = 8'($urandom);
      case ($urandom_range(0, 15))
        0: count = 16'h9999;
        1: count = 16'h0000;
        default: count = 16'($urandom_range(1, 9998));
      endcase
      cyc(1);
    end
    btn_r = 0; btn_p = 0;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
